mem_port_arbiter: RTL and testbench

Shares one single-port synchronous 32-bit RAM between the minrv32 instruction-fetch port and data port, replacing the dual-ported combinational memory model. Each requester uses a valid/ready handshake. Data stores to the console address are diverted to a byte-wide console stream with backpressure. Sits between minrv32 and the on-chip RAM macro; synthesizable.

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch and data ports,
// diverting console-address stores to a byte stream with backpressure.
module mem_port_arbiter #(
    parameter int          ADDR_W   = 18,
    parameter bit          ARB_RR   = 1'b1,
    parameter logic [31:0] CON_ADDR = 32'h1000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [31:0]       i_addr,
    output logic              i_ready,
    output logic [31:0]       i_rdata,
    input  logic              d_valid,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wstrb,
    input  logic [3:0]        d_rmask,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              con_valid,
    output logic [7:0]        con_data,
    input  logic              con_ready,
    output logic              bus_err
);

    typedef enum logic [1:0] {IDLE, ACK_I, ACK_D, CON} state_e;

    state_e      state_q;
    logic        last_d_q;
    logic        d_rd_q;
    logic        bus_err_q;
    logic        con_valid_q;
    logic [7:0]  con_data_q;
    logic [3:0]  rmask_q;

    logic        idle;
    logic        gnt_i;
    logic        gnt_d;
    logic        d_st;
    logic        d_con;
    logic        d_ram_hit;
    logic        d_ram_acc;
    logic [31:0] lane_mask;

    assign idle      = (state_q == IDLE) && !reset;
    assign gnt_i     = idle && i_valid && (!d_valid || (ARB_RR && last_d_q));
    assign gnt_d     = idle && d_valid && !gnt_i;
    assign d_st      = |d_wstrb;
    assign d_con     = (d_addr == CON_ADDR);
    assign d_ram_hit = (d_addr[31:ADDR_W] == '0) && !d_con;
    assign d_ram_acc = gnt_d && d_ram_hit;

    assign ram_en    = gnt_i || d_ram_acc;
    assign ram_we    = d_ram_acc ? d_wstrb : 4'b0;
    assign ram_wdata = d_ram_acc ? d_wdata : 32'b0;
    assign ram_addr  = gnt_i     ? i_addr[ADDR_W-1:2] :
                       d_ram_acc ? d_addr[ADDR_W-1:2] : '0;

    assign lane_mask = {{8{rmask_q[3]}}, {8{rmask_q[2]}},
                        {8{rmask_q[1]}}, {8{rmask_q[0]}}};

    assign i_ready   = (state_q == ACK_I);
    assign i_rdata   = i_ready ? ram_rdata : 32'b0;
    assign d_ready   = (state_q == ACK_D) || ((state_q == CON) && con_ready);
    assign d_rdata   = ((state_q == ACK_D) && d_rd_q) ? (ram_rdata & lane_mask) : 32'b0;
    assign con_valid = con_valid_q;
    assign con_data  = con_data_q;
    assign bus_err   = bus_err_q;

    logic unused_bits;
    assign unused_bits = ^{i_addr[31:ADDR_W], i_addr[1:0], d_addr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b1;
            d_rd_q      <= 1'b0;
            bus_err_q   <= 1'b0;
            con_valid_q <= 1'b0;
            con_data_q  <= 8'h00;
            rmask_q     <= 4'h0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    unique case (1'b1)
                        gnt_i: begin
                            state_q  <= ACK_I;
                            last_d_q <= 1'b0;
                        end
                        gnt_d: begin
                            last_d_q <= 1'b1;
                            rmask_q  <= d_rmask;
                            d_rd_q   <= d_ram_hit && !d_st;
                            unique case (1'b1)
                                d_con && d_st: begin
                                    con_valid_q <= 1'b1;
                                    con_data_q  <= d_wdata[7:0];
                                    state_q     <= CON;
                                end
                                d_con && !d_st: state_q <= ACK_D;
                                d_ram_hit:      state_q <= ACK_D;
                                default: begin
                                    bus_err_q <= 1'b1;
                                    state_q   <= ACK_D;
                                end
                            endcase
                        end
                        default: ;
                    endcase
                end
                ACK_I, ACK_D: state_q <= IDLE;
                CON: begin
                    if (con_ready) begin
                        con_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: round-robin instance with a RAM
// model plus a fixed-priority instance for the D-wins arbitration check.
module tb_mem_port_arbiter;

    logic        clk, reset;
    logic        i_valid, i_ready, d_valid, d_ready;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb, d_rmask, ram_we;
    logic        ram_en, con_valid, con_ready, bus_err;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [7:0]  con_data;

    logic        i_valid1, i_ready1, d_valid1, d_ready1;
    logic [31:0] i_addr1, i_rdata1, d_addr1, d_rdata1;
    logic [3:0]  d_rmask1, ram_we1;
    logic        ram_en1, con_valid1, bus_err1;
    logic [15:0] ram_addr1;
    logic [31:0] ram_wdata1;
    logic [7:0]  con_data1;

    logic [31:0] mem [0:65535];
    logic [31:0] iq[$];
    logic [31:0] dq[$];
    int          cyc, nvec, nerr;

    mem_port_arbiter #(.ADDR_W(18), .ARB_RR(1'b1)) u0 (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rmask(d_rmask), .d_ready(d_ready), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready),
        .bus_err(bus_err)
    );

    mem_port_arbiter #(.ADDR_W(18), .ARB_RR(1'b0)) u1 (
        .clk(clk), .reset(reset),
        .i_valid(i_valid1), .i_addr(i_addr1), .i_ready(i_ready1), .i_rdata(i_rdata1),
        .d_valid(d_valid1), .d_addr(d_addr1), .d_wdata(32'h0), .d_wstrb(4'h0),
        .d_rmask(d_rmask1), .d_ready(d_ready1), .d_rdata(d_rdata1),
        .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1),
        .ram_wdata(ram_wdata1), .ram_rdata(32'h0),
        .con_valid(con_valid1), .con_data(con_data1), .con_ready(1'b0),
        .bus_err(bus_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            if (ram_we == 4'b0) ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (i_ready) begin
                if (iq.size() == 0) chk("i_spurious", 32'(i_ready), 32'd0);
                else chk("i_rdata", i_rdata, iq.pop_front());
            end
            if (d_ready) begin
                if (dq.size() == 0) chk("d_spurious", 32'(d_ready), 32'd0);
                else chk("d_rdata", d_rdata, dq.pop_front());
            end
            if (i_ready || d_ready) chk("ready_excl", 32'(i_ready && d_ready), 32'd0);
        end
    end

    task automatic i_req(input logic [31:0] a, input logic [31:0] exp,
                         output int lat, output logic en0, output logic [15:0] ad0);
        i_valid = 1'b1;
        i_addr  = a;
        iq.push_back(exp);
        lat = -1;
        en0 = 1'b0;
        ad0 = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) begin
                en0 = ram_en;
                ad0 = ram_addr;
            end
            if (i_ready) begin
                lat = k;
                break;
            end
        end
        @(posedge clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic d_req(input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [3:0] rm,
                         input logic [31:0] exp, output int lat,
                         output logic en0, output logic [3:0] we0);
        d_valid = 1'b1;
        d_addr  = a;
        d_wdata = wd;
        d_wstrb = ws;
        d_rmask = rm;
        dq.push_back(exp);
        lat = -1;
        en0 = 1'b0;
        we0 = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) begin
                en0 = ram_en;
                we0 = ram_we;
            end
            if (d_ready) begin
                lat = k;
                break;
            end
        end
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        d_wstrb = 4'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic        en0;
        logic [3:0]  we0;
        logic [15:0] ad0;
        cyc = 0; nvec = 0; nerr = 0;
        reset = 1'b1;
        i_valid = 0; i_addr = 0; d_valid = 0; d_addr = 0;
        d_wdata = 0; d_wstrb = 0; d_rmask = 0; con_ready = 0;
        i_valid1 = 0; i_addr1 = 0; d_valid1 = 0; d_addr1 = 0; d_rmask1 = 0;

        repeat (2) @(negedge clk);
        chk("rst_i_ready", 32'(i_ready), 0);
        chk("rst_d_ready", 32'(d_ready), 0);
        chk("rst_ram_en", 32'(ram_en), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_con_valid", 32'(con_valid), 0);
        chk("rst_con_data", 32'(con_data), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        d_req(32'h100, 32'hDEADBEEF, 4'hF, 4'h0, 32'h0, lat, en0, we0);
        chk("st_lat", 32'(lat), 1);
        chk("st_we", 32'(we0), 32'hF);
        i_req(32'h100, 32'hDEADBEEF, lat, en0, ad0);
        chk("f_en", 32'(en0), 1);
        chk("f_addr", 32'(ad0), 32'h40);
        chk("f_lat", 32'(lat), 1);

        d_req(32'h200, 32'h11223344, 4'hF, 4'h0, 32'h0, lat, en0, we0);
        d_req(32'h200, 32'h000000AB, 4'h1, 4'hF, 32'h0, lat, en0, we0);
        chk("bst_we", 32'(we0), 32'h1);
        d_req(32'h200, 32'h0, 4'h0, 4'hF, 32'h112233AB, lat, en0, we0);
        chk("ld_en", 32'(en0), 1);
        chk("ld_we", 32'(we0), 0);
        d_req(32'h200, 32'h0, 4'h0, 4'h3, 32'h000033AB, lat, en0, we0);
        chk("ld_lat", 32'(lat), 1);

        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        i_valid = 1; i_addr = 32'h100;
        d_valid = 1; d_addr = 32'h200; d_wstrb = 0; d_rmask = 4'hF;
        iq.push_back(32'hDEADBEEF); iq.push_back(32'hDEADBEEF);
        dq.push_back(32'h112233AB); dq.push_back(32'h112233AB);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("tie_i%0d", k), 32'(i_ready), 32'(k == 1 || k == 5));
            chk($sformatf("tie_d%0d", k), 32'(d_ready), 32'(k == 3 || k == 7));
            if (k == 0) chk("tie_addr0", 32'(ram_addr), 32'h40);
            if (k == 2) chk("tie_addr2", 32'(ram_addr), 32'h80);
            @(posedge clk);
            #1;
        end
        i_valid = 0; d_valid = 0;

        d_valid = 1; d_addr = 32'h1000_0000; d_wdata = 32'h41;
        d_wstrb = 4'h1; con_ready = 0;
        dq.push_back(32'h0);
        @(negedge clk);
        chk("con_no_ram", 32'(ram_en), 0);
        @(posedge clk);
        #1 i_valid = 1; i_addr = 32'h200;
        iq.push_back(32'h112233AB);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("con_valid", 32'(con_valid), 1);
            chk("con_data", 32'(con_data), 32'h41);
            chk("con_stall_d", 32'(d_ready), 0);
            chk("con_stall_i", 32'(ram_en | i_ready), 0);
            @(posedge clk);
            #1;
        end
        con_ready = 1;
        @(negedge clk);
        chk("con_d_ready", 32'(d_ready), 1);
        @(posedge clk);
        #1 con_ready = 0; d_valid = 0; d_wstrb = 0;
        @(negedge clk);
        chk("con_clear", 32'(con_valid), 0);
        chk("con_i_grant", 32'(ram_en), 1);
        chk("con_i_addr", 32'(ram_addr), 32'h80);
        @(negedge clk);
        chk("con_i_ready", 32'(i_ready), 1);
        @(posedge clk);
        #1 i_valid = 0;

        d_req(32'h0004_0000, 32'h0, 4'h0, 4'hF, 32'h0, lat, en0, we0);
        chk("err_no_ram", 32'(en0), 0);
        chk("err_lat", 32'(lat), 1);
        chk("err_flag", 32'(bus_err), 1);
        i_req(32'h100, 32'hDEADBEEF, lat, en0, ad0);
        chk("err_sticky", 32'(bus_err), 1);

        d_valid = 1; d_addr = 32'h1000_0000; d_wdata = 32'h42; d_wstrb = 4'h1;
        repeat (2) @(negedge clk);
        chk("rc_con_valid", 32'(con_valid), 1);
        reset = 1'b1;
        #1;
        chk("rc_con_drop", 32'(con_valid), 0);
        chk("rc_bus_err", 32'(bus_err), 0);
        chk("rc_d_ready", 32'(d_ready), 0);
        d_valid = 0; d_wstrb = 0;
        @(negedge clk);
        chk("rc_d_ready2", 32'(d_ready), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        i_valid1 = 1; i_addr1 = 32'h0;
        d_valid1 = 1; d_addr1 = 32'h4; d_rmask1 = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("fx_d%0d", k), 32'(d_ready1), 32'(k == 1 || k == 3 || k == 5));
            chk($sformatf("fx_i%0d", k), 32'(i_ready1), 32'(k == 7));
            @(posedge clk);
            #1;
            if (k == 5) d_valid1 = 0;
        end
        i_valid1 = 0;

        repeat (2) @(negedge clk);
        chk("iq_empty", 32'(iq.size()), 0);
        chk("dq_empty", 32'(dq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
